// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode 7-segment
// display. A loaded binary value (saturated to 9999) is converted to BCD by a
// serial double-dabble engine and copied in one step into a shadow register.
// The scan side walks the digits at a fixed refresh rate and registers the
// anode enables and the shared BCD code for the external segment decoder.
//
// Handshake: load_i is a single-cycle strobe. It is accepted only on a cycle
// where busy_o is low at the sampling edge. busy_o rises on the edge after the
// accepted load, stays high for VALUE_W cycles, and falls on the edge that
// updates the shadow digits. A strobe that arrives while busy_o is high,
// including the cycle in which it falls, is dropped rather than queued.
module seg_scan_ctrl #(
   parameter int DIGITS      = 4,
   parameter int VALUE_W     = 14,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LZ    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [VALUE_W-1:0] value_i,
   input  logic               disp_en_i,
   output logic               busy_o,
   output logic [3:0]         digit_o,
   output logic [DIGITS-1:0]  an_o,
   output logic               dbg_state_o
);

   localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(VALUE_W + 1);
   localparam int BW = 4 * DIGITS;

   localparam logic [PW-1:0]      PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0]      IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [CW-1:0]      CNT_LAST   = CW'(VALUE_W - 1);
   localparam logic [VALUE_W-1:0] MAX_VAL    = VALUE_W'(9999);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // scan side
   logic [PW-1:0]     presc_q, presc_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [3:0]        digit_q, digit_d;
   logic [DIGITS-1:0] blank;
   logic              nz_seen;
   logic [3:0]        cur_code;

   // conversion side
   logic [0:0]         state_q, state_d;
   logic [VALUE_W-1:0] v_q, v_d;
   logic [BW-1:0]      bcd_q, bcd_d;
   logic [BW-1:0]      bcd_adj;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      shadow_q, shadow_d;

   // Prescaler and digit index: free-running, untouched by loads
   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Leading-zero mask: a digit is dark when it and every digit above it are zero
   always_comb begin
      blank   = '0;
      nz_seen = 1'b0;
      if (BLANK_LZ != 0) begin
         for (int i = DIGITS - 1; i > 0; i--) begin
            nz_seen  = nz_seen | (shadow_q[4*i +: 4] != 4'd0);
            blank[i] = ~nz_seen;
         end
      end
   end

   // Next anode/code outputs from the current index and the shadow digits
   always_comb begin
      cur_code = shadow_q[{idx_q, 2'b00} +: 4];
      an_d     = '1;
      digit_d  = 4'hF;
      if (disp_en_i) begin
         an_d    = ~(DIGITS'(1) << idx_q);
         digit_d = blank[idx_q] ? 4'hF : cur_code;
      end
   end

   // Double-dabble FSM: one add-3/shift step per cycle, shadow written at the end
   always_comb begin
      state_d  = state_q;
      v_d      = v_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      bcd_adj  = bcd_q;
      case (state_q)
         ST_IDLE: begin
            if (load_i) begin
               v_d     = (value_i > MAX_VAL) ? MAX_VAL : value_i;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            for (int i = 0; i < DIGITS; i++) begin
               if (bcd_q[4*i +: 4] >= 4'd5) begin
                  bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
               end
            end
            bcd_d = {bcd_adj[BW-2:0], v_q[VALUE_W-1]};
            v_d   = {v_q[VALUE_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               shadow_d = {bcd_adj[BW-2:0], v_q[VALUE_W-1]};
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q  <= '0;
         idx_q    <= '0;
         an_q     <= '1;
         digit_q  <= 4'hF;
         state_q  <= ST_IDLE;
         v_q      <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         an_q     <= an_d;
         digit_q  <= digit_d;
         state_q  <= state_d;
         v_q      <= v_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
      end
   end

   assign busy_o      = (state_q == ST_SHIFT);
   assign digit_o     = digit_q;
   assign an_o        = an_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: drives two controllers (leading-zero blanking on and off)
// with directed and random loads and display-enable patterns, and compares
// every cycle against a decimal-arithmetic model of what should be displayed.
module tb_seg_scan_ctrl;

   localparam int DIGITS  = 4;
   localparam int VALUE_W = 14;
   localparam int R       = 4;
   localparam int CONV    = VALUE_W;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // stimulus
   logic               load_i    = 1'b0;
   logic [VALUE_W-1:0] value_i   = '0;
   logic               disp_en_i = 1'b1;

   // DUT outputs
   logic              busy_o, busy_nb;
   logic [3:0]        digit_o, digit_nb;
   logic [DIGITS-1:0] an_o, an_nb;
   logic              dbg_state_o, dbg_state_nb;

   seg_scan_ctrl #(.DIGITS(DIGITS), .VALUE_W(VALUE_W), .REFRESH_DIV(R), .BLANK_LZ(1)) dut (
      .clk(clk), .rst_n(rst_n), .load_i(load_i), .value_i(value_i),
      .disp_en_i(disp_en_i), .busy_o(busy_o), .digit_o(digit_o),
      .an_o(an_o), .dbg_state_o(dbg_state_o)
   );

   seg_scan_ctrl #(.DIGITS(DIGITS), .VALUE_W(VALUE_W), .REFRESH_DIV(R), .BLANK_LZ(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .load_i(load_i), .value_i(value_i),
      .disp_en_i(disp_en_i), .busy_o(busy_nb), .digit_o(digit_nb),
      .an_o(an_nb), .dbg_state_o(dbg_state_nb)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: what the display should show, in decimal terms
   int m_edges     = 0;  // edges since reset release (drives the scan position)
   int m_busy_left = 0;  // conversion cycles still outstanding
   int m_pending   = 0;  // saturated value under conversion
   int m_shown     = 0;  // value currently held for display

   logic [12:0] exp_q[$];  // {busy, an, digit(blank lz), digit(no blank)}

   function automatic logic [3:0] model_digit(input int val, input int idx, input bit blank_lz);
      int p;
      p = 1;
      for (int i = 0; i < idx; i++) p = p * 10;
      if (blank_lz && idx > 0 && val < p) return 4'hF;
      return 4'((val / p) % 10);
   endfunction

   always @(posedge clk) begin : model
      logic [3:0] e_an, e_d, e_dnb;
      logic       e_busy;
      int         idx;
      if (!rst_n) begin
         m_edges     = 0;
         m_busy_left = 0;
         m_shown     = 0;
         e_an        = 4'hF;
         e_d         = 4'hF;
         e_dnb       = 4'hF;
      end else begin
         idx = (m_edges / R) % DIGITS;
         m_edges++;
         if (disp_en_i) begin
            e_an  = ~(4'b0001 << idx);
            e_d   = model_digit(m_shown, idx, 1'b1);
            e_dnb = model_digit(m_shown, idx, 1'b0);
         end else begin
            e_an  = 4'hF;
            e_d   = 4'hF;
            e_dnb = 4'hF;
         end
         if (m_busy_left == 0) begin
            if (load_i) begin
               m_pending   = (int'(value_i) > 9999) ? 9999 : int'(value_i);
               m_busy_left = CONV;
            end
         end else begin
            m_busy_left--;
            if (m_busy_left == 0) m_shown = m_pending;
         end
      end
      e_busy = (m_busy_left > 0);
      exp_q.push_back({e_busy, e_an, e_d, e_dnb});
   end

   // scoreboard: compare one expectation per edge, 1 time unit after the edge
   always @(posedge clk) begin : scoreboard
      logic [12:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("busy", busy_o, e[12]);
         check_eq("an", an_o, e[11:8]);
         check_eq("digit", digit_o, e[7:4]);
         check_eq("an_nb", an_nb, e[11:8]);
         check_eq("digit_nb", digit_nb, e[3:0]);
      end
   end

   // driver: single load from idle, then measure the busy window
   task automatic do_load(input int v);
      int n;
      @(negedge clk);
      load_i  = 1'b1;
      value_i = VALUE_W'(v);
      @(negedge clk);
      load_i = 1'b0;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         if (busy_o) n++;
         else break;
         @(negedge clk);
      end
      check_eq("busy_len", n, CONV);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // reset and bare scan: units shows 0, upper digits dark
      idle_cycles(3);
      rst_n = 1'b1;
      idle_cycles(20);

      // directed conversions, including saturation and interior zeros
      do_load(1234);  idle_cycles(18);
      do_load(10000); idle_cycles(18);
      do_load(16383); idle_cycles(18);
      do_load(1002);  idle_cycles(18);
      do_load(0);     idle_cycles(18);
      do_load(9999);  idle_cycles(18);

      // load while busy is dropped
      @(negedge clk); load_i = 1'b1; value_i = VALUE_W'(5);
      @(negedge clk); load_i = 1'b0;
      idle_cycles(2);
      load_i = 1'b1; value_i = VALUE_W'(77);
      @(negedge clk); load_i = 1'b0;
      idle_cycles(20);

      // strobe on the falling cycle is dropped, the following one is taken
      @(negedge clk); load_i = 1'b1; value_i = VALUE_W'(300);
      @(negedge clk); load_i = 1'b0;
      idle_cycles(13);
      load_i = 1'b1; value_i = VALUE_W'(555);
      @(negedge clk); value_i = VALUE_W'(666);
      @(negedge clk); load_i = 1'b0;
      idle_cycles(20);

      // reset mid-conversion, then a fresh load
      @(negedge clk); load_i = 1'b1; value_i = VALUE_W'(9876);
      @(negedge clk); load_i = 1'b0;
      idle_cycles(6);
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      idle_cycles(20);
      do_load(42); idle_cycles(18);

      // display enable toggling mid-scan
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         disp_en_i = 1'($urandom_range(0, 1));
      end
      disp_en_i = 1'b1;

      // random single loads with random blanking of the display
      for (int i = 0; i < 30; i++) begin
         do_load($urandom_range(0, 16383));
         for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            disp_en_i = ($urandom_range(0, 7) != 0);
         end
      end

      // random strobes every cycle, busy or not
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         load_i    = ($urandom_range(0, 3) == 0);
         value_i   = VALUE_W'($urandom_range(0, 16383));
         disp_en_i = ($urandom_range(0, 5) != 0);
      end
      load_i    = 1'b0;
      disp_en_i = 1'b1;
      idle_cycles(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
